// File: rtl/lsu_pkg.sv
// Shared encodings, FSM state type and size helpers for the lsu_align load/store unit.
package lsu_pkg;

  localparam logic [1:0] W_BYTE = 2'b00;
  localparam logic [1:0] W_HALF = 2'b01;
  localparam logic [1:0] W_WORD = 2'b10;

  // Base byte-enable masks indexed by width: {word, half, byte}.
  localparam logic [11:0] BYTE_MASK = {4'b1111, 4'b0011, 4'b0001};

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACC0,
    S_ACC1,
    S_CAP,
    S_DONE
  } lsu_state_e;

  function automatic logic [2:0] size_bytes(input logic [1:0] width);
    case (width)
      W_BYTE:  return 3'd1;
      W_HALF:  return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic crosses(input logic [1:0] off, input logic [1:0] width);
    return ({1'b0, off} + size_bytes(width)) > 3'd4;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: store shift and byte enables, load shift and extend.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  i_off,
  input  logic [1:0]  i_width,
  input  logic        i_usignext,
  input  logic [31:0] i_wdata,
  input  logic [63:0] i_rdata64,
  output logic [63:0] o_wdata_sh,
  output logic [7:0]  o_be8,
  output logic [31:0] o_ld_data,
  output logic        o_cross
);

  logic [1:0]  w_idx;
  logic [3:0]  w_be4;
  logic [4:0]  w_sh;
  logic [31:0] w_ld;

  assign w_idx      = (i_width == 2'b11) ? 2'd2 : i_width;
  assign w_be4      = BYTE_MASK[{w_idx, 2'b00} +: 4];
  assign w_sh       = {i_off, 3'b000};
  assign o_be8      = 8'(w_be4) << i_off;
  assign o_wdata_sh = 64'(i_wdata) << w_sh;
  assign o_cross    = crosses(i_off, i_width);

  // {hi, lo} is shifted so the addressed byte lands in lane 0.
  assign w_ld = 32'(i_rdata64 >> w_sh);

  always_comb begin
    o_ld_data = w_ld;
    case (i_width)
      W_BYTE: o_ld_data = i_usignext ? {24'h0, w_ld[7:0]}  : {{24{w_ld[7]}}, w_ld[7:0]};
      W_HALF: o_ld_data = i_usignext ? {16'h0, w_ld[15:0]} : {{16{w_ld[15]}}, w_ld[15:0]};
      default: o_ld_data = w_ld;
    endcase
  end

endmodule

// File: rtl/lsu_align.sv
// rv32 load/store unit: word-aligned memory port, byte enables, load extend, core pause.
// LSU_MISALIGN_SPLIT_EN: split word-crossing accesses into two word accesses; else fault them.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_width,
  input  logic              req_usignext,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              pause,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              misalign,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN-1:0]   mem_rdata,
  output lsu_state_e        dbg_state
);

  lsu_state_e        r_state;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_width;
  logic              r_usignext;
  logic [XLEN-1:0]   r_wdata;
  logic [XLEN-1:0]   r_lo;
  logic [XLEN-1:0]   r_resp_rdata;
`ifndef LSU_MISALIGN_SPLIT_EN
  logic              r_misalign;
`endif

  logic [63:0]       w_wdata_sh;
  logic [7:0]        w_be8;
  logic [31:0]       w_ld_data;
  logic              w_cross;
  logic [63:0]       w_rdata64;
  logic [ADDR_W-1:0] w_word0;
  logic [ADDR_W-1:0] w_word1;

  // Lane logic sees only latched request fields, never live req_* inputs.
  lsu_lane_align u_lane (
    .i_off      (r_addr[1:0]),
    .i_width    (r_width),
    .i_usignext (r_usignext),
    .i_wdata    (r_wdata),
    .i_rdata64  (w_rdata64),
    .o_wdata_sh (w_wdata_sh),
    .o_be8      (w_be8),
    .o_ld_data  (w_ld_data),
    .o_cross    (w_cross)
  );

  assign w_rdata64 = w_cross ? {mem_rdata, r_lo} : {32'h0, mem_rdata};
  assign w_word0   = {r_addr[ADDR_W-1:2], 2'b00};
  assign w_word1   = w_word0 + ADDR_W'(4);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_width      <= 2'b00;
      r_usignext   <= 1'b0;
      r_wdata      <= '0;
      r_lo         <= '0;
      r_resp_rdata <= '0;
`ifndef LSU_MISALIGN_SPLIT_EN
      r_misalign   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_we         <= req_we;
            r_addr       <= req_addr;
            r_width      <= req_width;
            r_usignext   <= req_usignext;
            r_wdata      <= req_wdata;
            r_resp_rdata <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
            r_state      <= S_ACC0;
`else
            r_misalign   <= crosses(req_addr[1:0], req_width);
            r_state      <= crosses(req_addr[1:0], req_width) ? S_DONE : S_ACC0;
`endif
          end
        end
        S_ACC0: begin
          if (w_cross)   r_state <= S_ACC1;
          else if (r_we) r_state <= S_DONE;
          else           r_state <= S_CAP;
        end
        S_ACC1: begin
          // Read data for word0 arrives now; word1 arrives during CAP.
          if (!r_we) r_lo <= mem_rdata;
          r_state <= r_we ? S_DONE : S_CAP;
        end
        S_CAP: begin
          r_resp_rdata <= w_ld_data;
          r_state      <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_be    = 4'b0000;
    mem_wdata = '0;
    case (r_state)
      S_ACC0: begin
        mem_en    = 1'b1;
        mem_we    = r_we;
        mem_addr  = w_word0;
        mem_be    = w_be8[3:0];
        mem_wdata = w_wdata_sh[31:0];
      end
      S_ACC1: begin
        mem_en    = 1'b1;
        mem_we    = r_we;
        mem_addr  = w_word1;
        mem_be    = w_be8[7:4];
        mem_wdata = w_wdata_sh[63:32];
      end
      default: ;
    endcase
  end

  assign pause = reset & ((r_state == S_ACC0) || (r_state == S_ACC1) || (r_state == S_CAP) ||
                          ((r_state == S_IDLE) && req_valid));
  assign resp_valid = (r_state == S_DONE);
  assign resp_rdata = r_resp_rdata;
  assign dbg_state  = r_state;

`ifdef LSU_MISALIGN_SPLIT_EN
  assign misalign = 1'b0;
`else
  assign misalign = (r_state == S_DONE) && r_misalign;
`endif

endmodule

// File: tb/tb_lsu_align.sv
// Directed table-driven bench for lsu_align with a memory responder and access scoreboard.
module tb_lsu_align;
  import lsu_pkg::*;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [1:0]  width;
    logic        usign;
    logic [31:0] wdata;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] exp_rdata;
    logic        exp_mis;
    int          exp_lat;
    int          exp_acc;
    logic [3:0]  exp_be0;
    logic [31:0] exp_wd0;
    logic [3:0]  exp_be1;
    logic [31:0] exp_wd1;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [1:0]  req_width;
  logic        req_usignext;
  logic [31:0] req_wdata;
  logic        pause;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        misalign;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  lsu_state_e  dbg_state;

  int n_total = 0;
  int n_bad   = 0;

  // Scoreboard entries: {we, addr, be, wdata-or-0}.
  logic [68:0] exp_q[$];
  logic [68:0] mon_obs;
  logic [68:0] mon_exp;

  logic [31:0] mem_a0, mem_d0, mem_a1, mem_d1;

  vec_t vecs[$];

  lsu_align #(.XLEN(32), .ADDR_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_width    (req_width),
    .req_usignext (req_usignext),
    .req_wdata    (req_wdata),
    .pause        (pause),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .misalign     (misalign),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_be       (mem_be),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- memory responder: read data the cycle after the read strobe ----------------
  always @(posedge clk) begin
    if (mem_en && !mem_we) begin
      if (mem_addr == mem_a0)      mem_rdata <= mem_d0;
      else if (mem_addr == mem_a1) mem_rdata <= mem_d1;
      else                         mem_rdata <= 32'hDEAD0000;
    end
  end

  // ---------------- access monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (mem_en) begin
      mon_obs = {mem_we, mem_addr, mem_be, (mem_we ? mem_wdata : 32'h0)};
      n_total++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL mem_access: unexpected access got %h want none", mon_obs);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_obs !== mon_exp) begin
          n_bad++;
          $display("FAIL mem_access: got %h want %h", mon_obs, mon_exp);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [1:0] width,
                              input logic usign, input logic [31:0] wdata, input logic [31:0] w0,
                              input logic [31:0] w1, input logic [31:0] exp_rdata,
                              input logic exp_mis, input int exp_lat, input int exp_acc,
                              input logic [3:0] be0, input logic [31:0] wd0,
                              input logic [3:0] be1, input logic [31:0] wd1);
    vec_t v;
    v.we = we; v.addr = addr; v.width = width; v.usign = usign; v.wdata = wdata;
    v.w0 = w0; v.w1 = w1; v.exp_rdata = exp_rdata; v.exp_mis = exp_mis;
    v.exp_lat = exp_lat; v.exp_acc = exp_acc;
    v.exp_be0 = be0; v.exp_wd0 = wd0; v.exp_be1 = be1; v.exp_wd1 = wd1;
    return v;
  endfunction

  task automatic load_exp(input vec_t v);
    logic [31:0] a0;
    a0 = v.addr & ~32'h3;
    mem_a0 = a0; mem_d0 = v.w0; mem_a1 = a0 + 32'd4; mem_d1 = v.w1;
    if (v.exp_acc > 0) exp_q.push_back({v.we, a0, v.exp_be0, (v.we ? v.exp_wd0 : 32'h0)});
    if (v.exp_acc > 1) exp_q.push_back({v.we, a0 + 32'd4, v.exp_be1, (v.we ? v.exp_wd1 : 32'h0)});
  endtask

  // Present a request for one cycle, then scramble req_* so any leak shows up.
  task automatic issue(input vec_t v);
    @(negedge clk);
    req_we = v.we; req_addr = v.addr; req_width = v.width;
    req_usignext = v.usign; req_wdata = v.wdata; req_valid = 1'b1;
    #1 chk("pause_on_req", pause, 1'b1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we = 1'($urandom_range(0, 1));
    req_addr = $urandom;
    req_width = 2'($urandom_range(0, 3));
    req_usignext = 1'($urandom_range(0, 1));
    req_wdata = $urandom;
  endtask

  task automatic run_vec(input vec_t v);
    int   n;
    logic got;
    load_exp(v);
    issue(v);
    n = 0;
    got = 1'b0;
    while (n < 8 && !got) begin
      @(negedge clk);
      n++;
      if (resp_valid) got = 1'b1;
      else chk("pause_busy", pause, 1'b1);
    end
    chk("resp_seen", got, 1'b1);
    chk("latency", 32'(n), 32'(v.exp_lat));
    chk("resp_rdata", resp_rdata, v.exp_rdata);
    chk("misalign", misalign, v.exp_mis);
    chk("pause_at_done", pause, 1'b0);
    @(negedge clk);
    chk("resp_pulse_end", resp_valid, 1'b0);
    chk("accesses_left", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin : main
    vec_t       vx;
    lsu_state_e tgt;
    logic       found;

    // Aligned and non-crossing cases: identical in both builds.
    vecs.push_back(mk(0, 32'h100, W_WORD, 0, 0, 32'h8899AABB, 0, 32'h8899AABB, 0, 3, 1, 4'b1111, 0, 0, 0));
    vecs.push_back(mk(0, 32'h103, W_BYTE, 0, 0, 32'h80FFFFFF, 0, 32'hFFFFFF80, 0, 3, 1, 4'b1000, 0, 0, 0));
    vecs.push_back(mk(0, 32'h103, W_BYTE, 1, 0, 32'h80FFFFFF, 0, 32'h00000080, 0, 3, 1, 4'b1000, 0, 0, 0));
    vecs.push_back(mk(1, 32'h102, W_HALF, 0, 32'h0000BEEF, 0, 0, 32'h0, 0, 2, 1, 4'b1100, 32'hBEEF0000, 0, 0));
    vecs.push_back(mk(1, 32'h201, W_BYTE, 0, 32'h000000A5, 0, 0, 32'h0, 0, 2, 1, 4'b0010, 32'h0000A500, 0, 0));
    vecs.push_back(mk(0, 32'h302, W_HALF, 0, 0, 32'h9ABC1234, 0, 32'hFFFF9ABC, 0, 3, 1, 4'b1100, 0, 0, 0));
    vecs.push_back(mk(0, 32'h301, W_HALF, 1, 0, 32'h11ABCD22, 0, 32'h0000ABCD, 0, 3, 1, 4'b0110, 0, 0, 0));
    vecs.push_back(mk(1, 32'h400, W_WORD, 0, 32'h12345678, 0, 0, 32'h0, 0, 2, 1, 4'b1111, 32'h12345678, 0, 0));
    vecs.push_back(mk(0, 32'h404, 2'b11, 0, 0, 32'h0BADF00D, 0, 32'h0BADF00D, 0, 3, 1, 4'b1111, 0, 0, 0));
    vecs.push_back(mk(0, 32'h500, W_BYTE, 0, 0, 32'h0000007F, 0, 32'h0000007F, 0, 3, 1, 4'b0001, 0, 0, 0));
`ifdef LSU_MISALIGN_SPLIT_EN
    vecs.push_back(mk(0, 32'h1FE, W_WORD, 0, 0, 32'h4433CCDD, 32'hEEFF2211, 32'h22114433, 0, 4, 2,
                      4'b1100, 0, 4'b0011, 0));
    vecs.push_back(mk(1, 32'hFFFFFFFF, W_WORD, 0, 32'hDEADBEEF, 0, 0, 32'h0, 0, 3, 2,
                      4'b1000, 32'hEF000000, 4'b0111, 32'h00DEADBE));
    vecs.push_back(mk(0, 32'h0FF, W_HALF, 1, 0, 32'hAB000000, 32'h000000CD, 32'h0000CDAB, 0, 4, 2,
                      4'b1000, 0, 4'b0001, 0));
`else
    vecs.push_back(mk(0, 32'h1FE, W_WORD, 0, 0, 32'h4433CCDD, 32'hEEFF2211, 32'h0, 1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 32'hFFFFFFFF, W_WORD, 0, 32'hDEADBEEF, 0, 0, 32'h0, 1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 32'h0FF, W_HALF, 1, 0, 32'hAB000000, 32'h000000CD, 32'h0, 1, 1, 0, 0, 0, 0, 0));
`endif

    // ---------------- reset ----------------
    mem_a0 = 0; mem_d0 = 0; mem_a1 = 0; mem_d1 = 0;
    reset = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h100; req_width = W_WORD;
    req_usignext = 1'b0; req_wdata = 32'h0;
    #3;
    chk("rst_pause", pause, 1'b0);
    chk("rst_mem_en", mem_en, 1'b0);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_misalign", misalign, 1'b0);
    chk("rst_state", 32'(dbg_state), 32'(S_IDLE));
    repeat (3) @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("idle_pause", pause, 1'b0);

    // ---------------- table ----------------
    foreach (vecs[i]) run_vec(vecs[i]);

    // ---------------- reset in the middle of an access ----------------
`ifdef LSU_MISALIGN_SPLIT_EN
    vx  = vecs[10];
    tgt = S_ACC1;
`else
    vx  = vecs[0];
    tgt = S_ACC0;
`endif
    load_exp(vx);
    issue(vx);
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      @(negedge clk);
      if (dbg_state == tgt) found = 1'b1;
    end
    chk("reach_mid_state", found, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("midrst_mem_en", mem_en, 1'b0);
    chk("midrst_pause", pause, 1'b0);
    chk("midrst_resp_valid", resp_valid, 1'b0);
    chk("midrst_state", 32'(dbg_state), 32'(S_IDLE));
    repeat (2) begin
      @(negedge clk);
      chk("midrst_quiet", mem_en, 1'b0);
    end
    reset = 1'b1;
    chk("midrst_accesses_left", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    @(negedge clk);
    chk("post_rst_state", 32'(dbg_state), 32'(S_IDLE));
    run_vec(vecs[0]);
    run_vec(vecs[3]);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
